pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipeline's stage registers (IF_ID, ID_EX, EX_MEM, MEM_WB) and the PC register.
- Generates a per-stage enable and flush from three conditions: data-memory wait handshake, taken-branch redirect from EX, and load-use hazard between ID and EX.
- Sits beside the datapath. Enables drive each register's en. Flushes are ORed with global reset at top level into each register's reset.
- Also keeps a sticky memory-timeout flag and a stall performance counter.

Parameters:
- REG_ADDR_W, 5, register-file address width
- LU_BUBBLES, 1, bubbles inserted per load-use hazard (1..7)
- MEM_TIMEOUT, 255, max consecutive MEM_WAIT cycles before timeout (1..65535)
- PERF_W, 16, stall counter width

Ports:
- clk  in  1  clock; state updates on falling edge, same as pipeline registers
- reset  in  1  synchronous, active-high
- id_rs1, id_rs2  in  REG_ADDR_W  source registers of the instruction in ID
- id_useRs1, id_useRs2  in  1  the ID instruction actually reads rs1/rs2
- ex_wba  in  REG_ADDR_W  destination register of the instruction in EX
- ex_MemtoReg, ex_regWen  in  1  EX instruction is a load / writes the register file
- ex_branchTaken  in  1  EX resolved a taken branch or jump
- mem_req, mem_ready  in  1  data-memory access active in MEM / data valid
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  stage register enables
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1  insert bubble (zero the register)
- mem_timeout  out  1  sticky timeout flag
- stall_cycles  out  PERF_W  saturating count of cycles with pc_en=0

Behaviour:
- State: FSM {RUN, LU_STALL, MEM_WAIT, HALT}, lu_cnt[2:0], wait_cnt[15:0], stall_cycles. All registered on negedge clk.
- Enable/flush outputs are combinational from state plus inputs, settled before the next falling edge.
- Reset, while asserted: all enables 0, all flushes 1. Next state RUN, counters 0, mem_timeout 0, stall_cycles 0.
- memstall = mem_req & ~mem_ready.
- luhaz = ex_MemtoReg & ex_regWen & (ex_wba != 0) & ((id_useRs1 & id_rs1 == ex_wba) | (id_useRs2 & id_rs2 == ex_wba)).
- Default (no condition): all enables 1, all flushes 0.
- Priority, highest first: HALT > memstall > ex_branchTaken > luhaz / LU_STALL.
- Freeze (memstall in any non-HALT state):
  - pc_en, ifid_en, idex_en, exmem_en = 0; memwb_flush = 1; memwb_en = 1.
  - Next state MEM_WAIT; wait_cnt increments.
  - In LU_STALL, lu_cnt is paused and the FSM returns to LU_STALL once memstall clears.
- MEM_WAIT with mem_ready = 1 (release cycle):
  - Outputs evaluated as in RUN: branch and hazard checks apply this cycle. wait_cnt cleared.
  - Next state RUN, or LU_STALL if the saved lu_cnt is nonzero.
- Timeout: wait_cnt reaching MEM_TIMEOUT while memstall sets mem_timeout and moves to HALT.
- HALT: freeze outputs permanently; exits only on reset.
- Branch redirect (no memstall): ifid_flush = 1, idex_flush = 1, all enables 1. Branch overrides luhaz, since the hazard instruction is squashed.
- Load-use (RUN, no memstall, no branch):
  - pc_en = 0, ifid_en = 0, idex_flush = 1, idex_en = 1, exmem/memwb enables 1.
  - If LU_BUBBLES > 1: enter LU_STALL with lu_cnt = LU_BUBBLES-1.
- LU_STALL:
  - Same outputs as load-use; lu_cnt decrements each non-frozen cycle; at lu_cnt = 1 the next state is RUN.
  - ex_branchTaken in LU_STALL applies the branch outputs and exits to RUN.
- stall_cycles: +1 on each non-reset cycle with pc_en = 0; saturates at all-ones.
- ex_wba = 0 never causes a hazard.
- mem_ready without mem_req is ignored.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - the state enum ctrl_state_t
  - a struct stage_ctrl_t {en, flush} per stage
  - constant REG_ZERO = 0
- One sub-module, hazard_detect, is natural: the combinational luhaz comparator, reusable by the forwarding unit.

Test Plan:
- Load x5 in EX, ID reads rs1 = x5 with use set, LU_BUBBLES = 1 -> one cycle with pc_en = 0, ifid_en = 0, idex_flush = 1, then all enables 1; stall_cycles = 1.
- Same hazard with LU_BUBBLES = 3 -> three consecutive bubble cycles, then RUN; stall_cycles = 3.
- mem_req = 1, mem_ready low for 4 cycles then high -> 4 freeze cycles with memwb_flush = 1, release cycle all enables 1, wait_cnt back to 0.
- ex_branchTaken and luhaz in the same cycle -> ifid_flush = idex_flush = 1, pc_en = 1, no LU_STALL entry.
- MEM_TIMEOUT = 8, mem_ready held low -> mem_timeout rises after 8 wait cycles and stays high with outputs frozen. A reset pulse clears the flag and restores RUN with flushes 1 during reset.
- Reset asserted mid-LU_STALL and mid-MEM_WAIT -> next cycle state RUN, counters 0, no residual stall.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard/stall sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_HALT     = 2'd3
  } ctrl_state_t;

  typedef struct packed {
    logic en;
    logic flush;
  } stage_ctrl_t;

  // Stage register slots. PC has no flush and always moves with IF/ID.
  localparam int NUM_STG   = 4;
  localparam int STG_IFID  = 0;
  localparam int STG_IDEX  = 1;
  localparam int STG_EXMEM = 2;
  localparam int STG_MEMWB = 3;

  // x0 is hardwired; a write to it never creates a dependency.
  localparam int REG_ZERO = 0;

  typedef stage_ctrl_t [NUM_STG-1:0] stage_vec_t;

  function automatic stage_vec_t ctrl_all(input logic en, input logic flush);
    stage_vec_t v;
    for (int i = 0; i < NUM_STG; i++) begin
      v[i].en    = en;
      v[i].flush = flush;
    end
    return v;
  endfunction

  // Hold everything up to EX/MEM; MEM/WB takes a bubble so WB does not repeat.
  function automatic stage_vec_t ctrl_freeze();
    stage_vec_t v;
    v = ctrl_all(1'b0, 1'b0);
    v[STG_MEMWB].en    = 1'b1;
    v[STG_MEMWB].flush = 1'b1;
    return v;
  endfunction

  // Redirect: squash the two younger instructions, keep everything moving.
  function automatic stage_vec_t ctrl_branch();
    stage_vec_t v;
    v = ctrl_all(1'b1, 1'b0);
    v[STG_IFID].flush = 1'b1;
    v[STG_IDEX].flush = 1'b1;
    return v;
  endfunction

  // Load-use bubble: hold IF/ID (and PC), push a bubble into ID/EX.
  function automatic stage_vec_t ctrl_luse();
    stage_vec_t v;
    v = ctrl_all(1'b1, 1'b0);
    v[STG_IFID].en    = 1'b0;
    v[STG_IDEX].flush = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator between the ID instruction and a load in EX.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_useRs1,
  input  logic                  id_useRs2,
  input  logic [REG_ADDR_W-1:0] ex_wba,
  input  logic                  ex_MemtoReg,
  input  logic                  ex_regWen,
  output logic                  luhaz
);

  logic src_hit;

  // Hazard when a load in EX writes a nonzero register the ID instruction reads.
  always_comb begin
    src_hit = (id_useRs1 && (id_rs1 == ex_wba)) || (id_useRs2 && (id_rs2 == ex_wba));
    luhaz   = ex_MemtoReg && ex_regWen && (ex_wba != REG_ADDR_W'(REG_ZERO)) && src_hit;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stage enable/flush sequencer: memory wait freeze, branch redirect,
// load-use bubbles, sticky memory timeout and a stall counter.
// State advances on the falling edge, like the pipeline registers.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int LU_BUBBLES  = 1,
  parameter int MEM_TIMEOUT = 255,
  parameter int PERF_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_useRs1,
  input  logic                  id_useRs2,
  input  logic [REG_ADDR_W-1:0] ex_wba,
  input  logic                  ex_MemtoReg,
  input  logic                  ex_regWen,
  input  logic                  ex_branchTaken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  idex_en,
  output logic                  exmem_en,
  output logic                  memwb_en,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exmem_flush,
  output logic                  memwb_flush,
  output logic                  mem_timeout,
  output logic [PERF_W-1:0]     stall_cycles
);

  ctrl_state_t       state, state_n;
  logic [2:0]        lu_cnt, lu_cnt_n;
  logic [15:0]       wait_cnt, wait_cnt_n;
  logic              timeout_n;
  logic [PERF_W-1:0] stall_n;
  logic              memstall;
  logic              luhaz;
  logic              wait_expired;
  stage_vec_t        ctrl;

  assign memstall     = mem_req & ~mem_ready;
  // Expires on the MEM_TIMEOUT-th consecutive wait cycle.
  assign wait_expired = (17'(wait_cnt) + 17'd1) >= 17'(MEM_TIMEOUT);

  hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_useRs1   (id_useRs1),
    .id_useRs2   (id_useRs2),
    .ex_wba      (ex_wba),
    .ex_MemtoReg (ex_MemtoReg),
    .ex_regWen   (ex_regWen),
    .luhaz       (luhaz)
  );

  // Per-stage enable/flush by priority: reset, halt/memstall, branch, load-use.
  always_comb begin
    ctrl = ctrl_all(1'b1, 1'b0);
    if (reset)
      ctrl = ctrl_all(1'b0, 1'b1);
    else if (state == ST_HALT || memstall)
      ctrl = ctrl_freeze();
    else if (ex_branchTaken)
      ctrl = ctrl_branch();
    else if (state == ST_LU_STALL || luhaz)
      ctrl = ctrl_luse();
  end

  // PC never advances without IF/ID, so they share one enable.
  assign pc_en       = ctrl[STG_IFID].en;
  assign ifid_en     = ctrl[STG_IFID].en;
  assign idex_en     = ctrl[STG_IDEX].en;
  assign exmem_en    = ctrl[STG_EXMEM].en;
  assign memwb_en    = ctrl[STG_MEMWB].en;
  assign ifid_flush  = ctrl[STG_IFID].flush;
  assign idex_flush  = ctrl[STG_IDEX].flush;
  assign exmem_flush = ctrl[STG_EXMEM].flush;
  assign memwb_flush = ctrl[STG_MEMWB].flush;

  // Next state and counters; lu_cnt survives a memory freeze so the
  // remaining bubbles resume after the release cycle.
  always_comb begin
    state_n    = state;
    lu_cnt_n   = lu_cnt;
    wait_cnt_n = wait_cnt;
    timeout_n  = mem_timeout;
    stall_n    = stall_cycles;
    if (!pc_en && stall_cycles != {PERF_W{1'b1}})
      stall_n = stall_cycles + 1'b1;
    if (state != ST_HALT) begin
      if (memstall) begin
        wait_cnt_n = wait_cnt + 16'd1;
        if (wait_expired) begin
          state_n   = ST_HALT;
          timeout_n = 1'b1;
        end else begin
          state_n = ST_MEM_WAIT;
        end
      end else begin
        wait_cnt_n = '0;
        if (ex_branchTaken) begin
          state_n  = ST_RUN;
          lu_cnt_n = '0;
        end else if (state == ST_LU_STALL) begin
          if (lu_cnt <= 3'd1) begin
            state_n  = ST_RUN;
            lu_cnt_n = '0;
          end else begin
            lu_cnt_n = lu_cnt - 3'd1;
          end
        end else if (luhaz && LU_BUBBLES > 1) begin
          state_n  = ST_LU_STALL;
          lu_cnt_n = 3'(LU_BUBBLES - 1);
        end else if (lu_cnt != '0) begin
          state_n = ST_LU_STALL;
        end else begin
          state_n = ST_RUN;
        end
      end
    end
  end

  // State registers on the falling edge with synchronous reset.
  always_ff @(negedge clk) begin
    if (reset) begin
      state        <= ST_RUN;
      lu_cnt       <= '0;
      wait_cnt     <= '0;
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state        <= state_n;
      lu_cnt       <= lu_cnt_n;
      wait_cnt     <= wait_cnt_n;
      mem_timeout  <= timeout_n;
      stall_cycles <= stall_n;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: two controllers (1 and 3 load-use bubbles, 4-bit stall
// counter on the second) share stimulus; expected outputs come from a
// cycle model built on remaining-bubble / wait-length counts.
module tb_pipe_hazard_ctrl;

  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_wba;
  logic       id_useRs1, id_useRs2, ex_MemtoReg, ex_regWen, ex_branchTaken;
  logic       mem_req, mem_ready;

  logic [1:0] pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic [1:0] ifid_flush, idex_flush, exmem_flush, memwb_flush, mem_timeout;
  logic [15:0] stall_a;
  logic [3:0]  stall_b;

  pipe_hazard_ctrl #(.REG_ADDR_W(5), .LU_BUBBLES(1), .MEM_TIMEOUT(TO), .PERF_W(16)) u_a (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_useRs1(id_useRs1), .id_useRs2(id_useRs2), .ex_wba(ex_wba),
    .ex_MemtoReg(ex_MemtoReg), .ex_regWen(ex_regWen), .ex_branchTaken(ex_branchTaken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en[0]), .ifid_en(ifid_en[0]), .idex_en(idex_en[0]),
    .exmem_en(exmem_en[0]), .memwb_en(memwb_en[0]),
    .ifid_flush(ifid_flush[0]), .idex_flush(idex_flush[0]),
    .exmem_flush(exmem_flush[0]), .memwb_flush(memwb_flush[0]),
    .mem_timeout(mem_timeout[0]), .stall_cycles(stall_a));

  pipe_hazard_ctrl #(.REG_ADDR_W(5), .LU_BUBBLES(3), .MEM_TIMEOUT(TO), .PERF_W(4)) u_b (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_useRs1(id_useRs1), .id_useRs2(id_useRs2), .ex_wba(ex_wba),
    .ex_MemtoReg(ex_MemtoReg), .ex_regWen(ex_regWen), .ex_branchTaken(ex_branchTaken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en[1]), .ifid_en(ifid_en[1]), .idex_en(idex_en[1]),
    .exmem_en(exmem_en[1]), .memwb_en(memwb_en[1]),
    .ifid_flush(ifid_flush[1]), .idex_flush(idex_flush[1]),
    .exmem_flush(exmem_flush[1]), .memwb_flush(memwb_flush[1]),
    .mem_timeout(mem_timeout[1]), .stall_cycles(stall_b));

  // {pc,ifid,idex,exmem,memwb en, ifid,idex,exmem,memwb flush, timeout, stalls}
  logic [25:0] obs_a, obs_b;
  assign obs_a = {pc_en[0], ifid_en[0], idex_en[0], exmem_en[0], memwb_en[0],
                  ifid_flush[0], idex_flush[0], exmem_flush[0], memwb_flush[0],
                  mem_timeout[0], stall_a};
  assign obs_b = {pc_en[1], ifid_en[1], idex_en[1], exmem_en[1], memwb_en[1],
                  ifid_flush[1], idex_flush[1], exmem_flush[1], memwb_flush[1],
                  mem_timeout[1], 12'd0, stall_b};

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1, rs2, wba;
    logic       u1, u2, m2r, wen, br, req, rdy;
  } stim_t;

  typedef struct {
    int          inst;
    int          cyc;
    logic [25:0] exp;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   failed = 0;
  int   cyc = 0;

  // Reference model state: halted flag, bubbles still owed, length of the
  // current memory wait, sticky timeout, stall count.
  bit m_halt[2];
  int m_bub[2];
  int m_wait[2];
  bit m_to[2];
  int m_stall[2];
  int LUB[2] = '{1, 3};
  int SAT[2] = '{65535, 15};

  task automatic model_step(input int k, input stim_t s, output logic [25:0] e);
    logic [4:0] en;
    logic [3:0] fl;
    bit ms, haz, rel;
    ms  = s.req && !s.rdy;
    haz = s.m2r && s.wen && (s.wba != 0) &&
          ((s.u1 && s.rs1 == s.wba) || (s.u2 && s.rs2 == s.wba));
    rel = (m_wait[k] > 0);
    if (s.rst) begin
      en = 5'b00000; fl = 4'b1111;
    end else if (m_halt[k] || ms) begin
      en = 5'b00001; fl = 4'b0001;
    end else if (s.br) begin
      en = 5'b11111; fl = 4'b1100;
    end else if ((m_bub[k] > 0 && !rel) || haz) begin
      en = 5'b00111; fl = 4'b0100;
    end else begin
      en = 5'b11111; fl = 4'b0000;
    end
    e = {en, fl, m_to[k], 16'(m_stall[k])};
    if (s.rst) begin
      m_halt[k] = 0; m_bub[k] = 0; m_wait[k] = 0; m_to[k] = 0; m_stall[k] = 0;
    end else begin
      if (en[4] == 1'b0 && m_stall[k] < SAT[k]) m_stall[k]++;
      if (!m_halt[k]) begin
        if (ms) begin
          m_wait[k]++;
          if (m_wait[k] >= TO) begin
            m_halt[k] = 1; m_to[k] = 1;
          end
        end else begin
          m_wait[k] = 0;
          if (s.br) m_bub[k] = 0;
          else if (!rel && m_bub[k] > 0) m_bub[k]--;
          else if (haz) m_bub[k] = LUB[k] - 1;
        end
      end
    end
  endtask

  task automatic apply(input stim_t s);
    reset = s.rst; id_rs1 = s.rs1; id_rs2 = s.rs2; ex_wba = s.wba;
    id_useRs1 = s.u1; id_useRs2 = s.u2; ex_MemtoReg = s.m2r; ex_regWen = s.wen;
    ex_branchTaken = s.br; mem_req = s.req; mem_ready = s.rdy;
  endtask

  task automatic step(input stim_t s);
    logic [25:0] e;
    @(posedge clk);
    #1;
    apply(s);
    for (int k = 0; k < 2; k++) begin
      model_step(k, s, e);
      q.push_back('{inst: k, cyc: cyc, exp: e});
    end
    cyc++;
  endtask

  task automatic repeat_step(input stim_t s, input int n);
    for (int i = 0; i < n; i++) step(s);
  endtask

  // Monitor: outputs are valid every cycle; compare mid-way between edges.
  initial begin
    exp_t it;
    logic [25:0] got;
    forever begin
      @(posedge clk);
      #3;
      while (q.size() > 0) begin
        it  = q.pop_front();
        got = (it.inst == 0) ? obs_a : obs_b;
        tests++;
        if (got !== it.exp) begin
          failed++;
          $display("FAIL ctrl_inst%0d cyc=%0d got=%h exp=%h", it.inst, it.cyc, got, it.exp);
        end
      end
    end
  end

  initial begin
    stim_t idle, rst, haz, ms, rel, s;
    idle = '0;
    rst = idle; rst.rst = 1'b1;
    haz = idle; haz.m2r = 1; haz.wen = 1; haz.wba = 5'd5; haz.rs1 = 5'd5; haz.u1 = 1;
    ms  = idle; ms.req = 1; ms.rdy = 0;
    rel = idle; rel.req = 1; rel.rdy = 1;

    apply(rst);
    repeat (2) @(negedge clk);

    repeat_step(rst, 2);
    // load-use, 1 vs 3 bubbles
    step(haz);
    repeat_step(idle, 5);
    // load-use via rs2, and x0 destination (no hazard)
    s = haz; s.u1 = 0; s.rs2 = 5'd5; s.u2 = 1; step(s);
    repeat_step(idle, 4);
    s = haz; s.wba = 0; s.rs1 = 0; step(s);
    step(idle);
    // memory wait then release
    repeat_step(rst, 1);
    repeat_step(ms, 4);
    step(rel);
    repeat_step(idle, 2);
    // ready without request
    s = idle; s.rdy = 1; step(s);
    // branch and hazard together
    s = haz; s.br = 1; step(s);
    repeat_step(idle, 3);
    // memory freeze during LU_STALL, then resume remaining bubbles
    step(haz);
    repeat_step(ms, 2);
    step(rel);
    repeat_step(idle, 4);
    // branch during LU_STALL
    step(haz);
    s = idle; s.br = 1; step(s);
    repeat_step(idle, 2);
    // timeout and halt, then reset recovery
    repeat_step(ms, 10);
    repeat_step(idle, 3);
    step(rst);
    repeat_step(idle, 2);
    // reset mid LU_STALL and mid MEM_WAIT
    step(haz);
    step(rst);
    repeat_step(idle, 3);
    repeat_step(ms, 3);
    step(rst);
    repeat_step(idle, 2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      s.rst = ($urandom_range(0, 49) == 0);
      s.rs1 = 5'($urandom_range(0, 3));
      s.rs2 = 5'($urandom_range(0, 3));
      s.wba = 5'($urandom_range(0, 3));
      s.u1  = 1'($urandom_range(0, 1));
      s.u2  = 1'($urandom_range(0, 1));
      s.m2r = 1'($urandom_range(0, 1));
      s.wen = ($urandom_range(0, 3) != 0);
      s.br  = ($urandom_range(0, 99) < 12);
      s.req = ($urandom_range(0, 99) < 35);
      s.rdy = ($urandom_range(0, 99) < 45);
      step(s);
    end

    @(posedge clk);
    #5;
    tests++;
    if (q.size() != 0) begin
      failed++;
      $display("FAIL queue_drain left=%0d exp=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
